// File: rtl/freq_meas_ctrl.sv
// Frequency measurement sequencer: picks the prescaler ratio, resets the divider chain,
// counts divided-signal edges over a fixed gate window and publishes the count.
// Optional auto-ranging retries one range up on overflow, and selects one range down for
// the next run when the count is below a quarter of full scale.
module freq_meas_ctrl #(
  parameter int unsigned GATE_CYCLES   = 1000,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             cont,
  input  logic             auto_range,
  input  logic [1:0]       man_sel,
  input  logic             sig_div,
  output logic [1:0]       div_sel,
  output logic             div_rst,
  output logic             busy,
  output logic [CNT_W-1:0] result,
  output logic [1:0]       result_sel,
  output logic             result_ovf,
  output logic             result_valid
);

  localparam int unsigned TmrMax = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int unsigned TmrW   = $clog2(TmrMax + 1);
  localparam logic [TmrW-1:0] SettleLast = TmrW'(SETTLE_CYCLES - 1);
  localparam logic [TmrW-1:0] GateLast   = TmrW'(GATE_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StSettle, StGate, StLatch} state_e;

  state_e           state_q, state_d;
  logic [TmrW-1:0]  timer_q, timer_d;
  logic [1:0]       div_sel_q, div_sel_d;
  logic             div_rst_q;
  logic [CNT_W-1:0] count_q;
  logic             ovf_q;
  logic [1:0]       sync_q;
  logic             sig_prev_q;
  logic             sig_edge;
  logic             enter_settle;
  logic             publish;
  logic             retry;
  logic             under_range;
  logic [CNT_W-1:0] result_q;
  logic [1:0]       result_sel_q;
  logic             result_ovf_q;
  logic             result_valid_q;

  assign sig_edge    = sync_q[1] & ~sig_prev_q;
  // Count below 2^(CNT_W-2) means the top two bits are clear.
  assign under_range = (count_q[CNT_W-1 -: 2] == 2'b00);

  // Next-state decode; abort overrides every other transition.
  always_comb begin
    state_d      = state_q;
    enter_settle = 1'b0;
    publish      = 1'b0;
    retry        = 1'b0;
    case (state_q)
      StIdle:   if (start) enter_settle = 1'b1;
      StSettle: if (timer_q == SettleLast) state_d = StGate;
      StGate:   if (timer_q == GateLast) state_d = StLatch;
      StLatch: begin
        if (ovf_q && auto_range && (div_sel_q != 2'd3)) begin
          retry        = 1'b1;
          enter_settle = 1'b1;
        end else begin
          publish = 1'b1;
          if (cont) enter_settle = 1'b1;
          else      state_d      = StIdle;
        end
      end
      default:  state_d = StIdle;
    endcase
    if (enter_settle) state_d = StSettle;
    if (abort) begin
      state_d      = StIdle;
      enter_settle = 1'b0;
      publish      = 1'b0;
      retry        = 1'b0;
    end
  end

  // Phase timer restarts on every state change and idles at zero.
  always_comb begin
    timer_d = timer_q + TmrW'(1);
    if ((state_q == StIdle) || (state_d != state_q)) timer_d = '0;
  end

  // Range selection: step up on retry, load manual on entry, step down after a weak result.
  always_comb begin
    div_sel_d = div_sel_q;
    if (retry) begin
      div_sel_d = div_sel_q + 2'd1;
    end else if (enter_settle && !auto_range) begin
      div_sel_d = man_sel;
    end else if (publish && auto_range && (div_sel_q != 2'd0) && under_range) begin
      div_sel_d = div_sel_q - 2'd1;
    end
  end

  // FSM, timer, range and divider-reset registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      div_sel_q <= 2'd0;
      div_rst_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      div_sel_q <= div_sel_d;
      div_rst_q <= enter_settle;
    end
  end

  // Two-flop synchroniser plus edge-detect history for the asynchronous divided signal.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q     <= 2'b00;
      sig_prev_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], sig_div};
      sig_prev_q <= sync_q[1];
    end
  end

  // Saturating edge counter, live only during the gate window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else if (enter_settle) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else if ((state_q == StGate) && sig_edge) begin
      if (count_q == '1) ovf_q   <= 1'b1;
      else               count_q <= count_q + CNT_W'(1);
    end
  end

  // Published result registers and their strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q       <= '0;
      result_sel_q   <= 2'd0;
      result_ovf_q   <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      result_valid_q <= publish;
      if (publish) begin
        result_q     <= count_q;
        result_sel_q <= div_sel_q;
        result_ovf_q <= ovf_q;
      end
    end
  end

  assign div_sel      = div_sel_q;
  assign div_rst      = div_rst_q;
  assign busy         = (state_q != StIdle);
  assign result       = result_q;
  assign result_sel   = result_sel_q;
  assign result_ovf   = result_ovf_q;
  assign result_valid = result_valid_q;

endmodule
